sram_burst_reader: RTL and testbench

- Client-side requester for the SRAM controller's request ports. Accepts a burst command (start address, word count) and issues one-word read requests into a controller port.
- Collects the in-order DataReady/DataFromSRAM responses and streams them out on a valid/ready interface with a last flag.
- Sits in the BOARD_CLK domain between a pixel/data consumer (e.g. video scan-out) and one of the SRAM controller's four ports.
- Bounds outstanding requests by its own buffer space, so responses can never overflow.

---
 rtl/typhoon_sram_pkg.sv | 13 +
 rtl/sram_resp_fifo.sv | 47 ++++
 rtl/sram_burst_reader.sv | 115 +++++++++++
 tb/tb_sram_burst_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/typhoon_sram_pkg.sv
// Shared SRAM widths and burst reader state encoding.
// Used by the SRAM controller and its port clients.
package typhoon_sram_pkg;
  localparam int SRAM_ADDR_W    = 20;
  localparam int SRAM_DATA_W    = 16;
  localparam int SRAM_NUM_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } reader_state_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// Response buffer for the burst reader.
// Head word is held in registered storage.
module sram_resp_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/sram_burst_reader.sv
// Burst read client for one SRAM controller port.
// Issue is throttled by buffer credits so responses never overflow.
module sram_burst_reader
  import typhoon_sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int LEN_W     = 12,
  parameter int BUF_DEPTH = 8
) (
  input  logic              BOARD_CLK,
  input  logic              RESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              QueueReadReq,
  output logic [ADDR_W-1:0] AddressToSRAM,
  input  logic              DataReady,
  input  logic [DATA_W-1:0] DataFromSRAM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_unexpected
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  reader_state_t     state, state_n;
  logic [ADDR_W-1:0] cur_addr, iss_addr;
  logic [LEN_W-1:0]  remaining, iss_rem;
  logic [LEN_W-1:0]  pop_left;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     outstanding;
  logic              issue, last_pop, pop;
  logic              resp_wr, fifo_full, fifo_empty;

  assign pop     = out_valid && out_ready;
  assign resp_wr = DataReady && (outstanding != '0) && (!fifo_full || pop);

  // The first request is issued straight from IDLE on acceptance.
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    last_pop = 1'b0;
    iss_addr = cur_addr;
    iss_rem  = remaining;
    unique case (state)
      IDLE: begin
        iss_addr = cmd_addr;
        iss_rem  = cmd_len;
        issue    = cmd_valid && (cmd_len != '0);
      end
      ISSUE: issue = (credits < CW'(BUF_DEPTH));
      DRAIN: begin
        if (pop && pop_left == LEN_W'(1)) begin
          state_n  = IDLE;
          last_pop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (issue) state_n = (iss_rem == LEN_W'(1)) ? DRAIN : ISSUE;
  end

  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      cur_addr       <= '0;
      remaining      <= '0;
      pop_left       <= '0;
      credits        <= '0;
      outstanding    <= '0;
      QueueReadReq   <= 1'b0;
      AddressToSRAM  <= '0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      state        <= state_n;
      QueueReadReq <= issue;
      if (issue) begin
        AddressToSRAM <= iss_addr;
        cur_addr      <= iss_addr + ADDR_W'(1);
        remaining     <= iss_rem - LEN_W'(1);
      end
      if (state == IDLE && cmd_valid) pop_left <= cmd_len;
      else if (pop) pop_left <= pop_left - LEN_W'(1);
      credits     <= credits + CW'(issue) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(resp_wr);
      if (DataReady && outstanding == '0) err_unexpected <= 1'b1;
      done <= (state == IDLE && cmd_valid && cmd_len == '0) || last_pop;
    end
  end

  sram_resp_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (BOARD_CLK),
    .rst_n (RESET_N),
    .push  (resp_wr),
    .wdata (DataFromSRAM),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_last  = out_valid && (pop_left == LEN_W'(1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a 3-cycle SRAM responder.
// Bursts come from a vector table; corner cases are hand sequences.
module tb_sram_burst_reader;
  logic        BOARD_CLK = 1'b0;
  logic        RESET_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        QueueReadReq;
  logic [19:0] AddressToSRAM;
  logic        DataReady;
  logic [15:0] DataFromSRAM;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_unexpected;

  sram_burst_reader dut (
    .BOARD_CLK      (BOARD_CLK),
    .RESET_N        (RESET_N),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .QueueReadReq   (QueueReadReq),
    .AddressToSRAM  (AddressToSRAM),
    .DataReady      (DataReady),
    .DataFromSRAM   (DataFromSRAM),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .err_unexpected (err_unexpected)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge BOARD_CLK) cyc++;

  function automatic logic [15:0] mem_word(logic [19:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {12'h000, a[19:16]};
  endfunction

  // SRAM model: each request answered exactly 3 cycles later
  logic        pv [3] = '{1'b0, 1'b0, 1'b0};
  logic [19:0] pa [3] = '{20'h0, 20'h0, 20'h0};
  logic        inject = 1'b0;
  initial begin
    DataReady    = 1'b0;
    DataFromSRAM = 16'h0;
    forever begin
      @(posedge BOARD_CLK);
      #1;
      DataReady    = pv[2] | inject;
      DataFromSRAM = pv[2] ? mem_word(pa[2]) : 16'hDEAD;
      pv[2] = pv[1]; pa[2] = pa[1];
      pv[1] = pv[0]; pa[1] = pa[0];
      pv[0] = QueueReadReq; pa[0] = AddressToSRAM;
    end
  end

  logic [19:0] s_addr[$];
  int          s_cyc[$];
  logic [15:0] p_data[$];
  logic        p_last[$];
  int          p_cyc;
  int          done_cnt;
  int          done_cyc;
  logic        rdy_at_done;
  logic        busy_seen;
  logic        valid_seen;

  always @(negedge BOARD_CLK) begin
    if (QueueReadReq) begin
      s_addr.push_back(AddressToSRAM);
      s_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      p_data.push_back(out_data);
      p_last.push_back(out_last);
      p_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      rdy_at_done = cmd_ready;
    end
    busy_seen  = busy_seen | busy;
    valid_seen = valid_seen | out_valid;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    s_addr.delete(); s_cyc.delete();
    p_data.delete(); p_last.delete();
    p_cyc = -1; done_cnt = 0; done_cyc = -1;
    rdy_at_done = 1'b0; busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  task automatic start_burst(input logic [19:0] a, input logic [11:0] n,
                             output int acc);
    @(posedge BOARD_CLK);
    #1;
    clear_mon();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    @(posedge BOARD_CLK);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(posedge BOARD_CLK);
      #1;
      i++;
    end
    check("done_within_budget", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge BOARD_CLK);
    #1;
  endtask

  task automatic verify(input logic [19:0] a, input int n, input int acc,
                        input bit timed);
    logic [19:0] ea;
    check("strobe_count", 32'(s_addr.size()), 32'(n));
    check("word_count", 32'(p_data.size()), 32'(n));
    for (int i = 0; i < n && i < s_addr.size(); i++) begin
      ea = a + 20'(i);
      check($sformatf("req_addr[%0d]", i), 32'(s_addr[i]), 32'(ea));
      if (timed) check($sformatf("req_cycle[%0d]", i), s_cyc[i], acc + i);
    end
    for (int i = 0; i < n && i < p_data.size(); i++) begin
      ea = a + 20'(i);
      check($sformatf("out_data[%0d]", i), 32'(p_data[i]), 32'(mem_word(ea)));
      check($sformatf("out_last[%0d]", i), 32'(p_last[i]), 32'(i == n - 1));
    end
    check("done_pulses", done_cnt, 1);
    if (n > 0) check("done_after_last_pop", done_cyc, p_cyc + 1);
    else check("done_after_accept", done_cyc, acc);
    check("cmd_ready_with_done", 32'(rdy_at_done), 32'd1);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_req"}, 32'(QueueReadReq), 32'd0);
    check({tag, "_addr"}, 32'(AddressToSRAM), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_unexpected), 32'd0);
  endtask

  typedef struct {
    logic [19:0] addr;
    logic [11:0] len;
    int          exp_strobes;
    logic [19:0] exp_end_addr;
  } vec_t;

  vec_t vecs[5];
  int   acc;

  initial begin
    vecs[0] = '{20'h00100, 12'd4, 4, 20'h00103};
    vecs[1] = '{20'hFFFFE, 12'd4, 4, 20'h00001};
    vecs[2] = '{20'h00000, 12'd0, 0, 20'h00000};
    vecs[3] = '{20'h12345, 12'd1, 1, 20'h12345};
    vecs[4] = '{20'h0ABCD, 12'd9, 9, 20'h0ABD5};

    RESET_N   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    clear_mon();
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge BOARD_CLK);
    RESET_N = 1'b1;

    for (int v = 0; v < 5; v++) begin
      start_burst(vecs[v].addr, vecs[v].len, acc);
      wait_done(100);
      verify(vecs[v].addr, int'(vecs[v].len), acc, 1'b1);
      check($sformatf("v%0d_strobes", v), 32'(s_addr.size()),
            32'(vecs[v].exp_strobes));
      if (vecs[v].exp_strobes > 0 && s_addr.size() > 0)
        check($sformatf("v%0d_end_addr", v), 32'(s_addr[s_addr.size()-1]),
              32'(vecs[v].exp_end_addr));
      if (vecs[v].len == 0) begin
        check("len0_busy_seen", 32'(busy_seen), 32'd0);
        check("len0_valid_seen", 32'(valid_seen), 32'd0);
      end
    end

    // Backpressure: only BUF_DEPTH requests may be outstanding.
    out_ready = 1'b0;
    start_burst(20'h00400, 12'd20, acc);
    repeat (40) @(posedge BOARD_CLK);
    #1;
    check("bp_strobes_held", 32'(s_addr.size()), 32'd8);
    check("bp_req_idle", 32'(QueueReadReq), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done(300);
    verify(20'h00400, 20, acc, 1'b0);

    // Stray response while idle.
    check("err_clear_before", 32'(err_unexpected), 32'd0);
    clear_mon();
    @(negedge BOARD_CLK);
    inject = 1'b1;
    @(posedge BOARD_CLK);
    #2;
    inject = 1'b0;
    repeat (4) @(posedge BOARD_CLK);
    #1;
    check("err_set", 32'(err_unexpected), 32'd1);
    check("err_no_word", 32'(valid_seen), 32'd0);
    start_burst(20'h00200, 12'd3, acc);
    wait_done(100);
    verify(20'h00200, 3, acc, 1'b1);
    check("err_sticky", 32'(err_unexpected), 32'd1);

    // Reset after 3 of 6 requests have gone out.
    start_burst(20'h00600, 12'd6, acc);
    for (int i = 0; i < 50 && s_addr.size() < 3; i++) begin
      @(negedge BOARD_CLK);
      #1;
    end
    check("rst_mid_strobes", 32'(s_addr.size()), 32'd3);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("mid");
    #1;
    RESET_N = 1'b1;
    clear_mon();
    repeat (8) @(posedge BOARD_CLK);
    #1;
    check("rst_late_resp_err", 32'(err_unexpected), 32'd1);
    check("rst_no_word", 32'(valid_seen), 32'd0);
    check("rst_no_req", 32'(s_addr.size()), 32'd0);
    start_burst(20'h00700, 12'd2, acc);
    wait_done(100);
    verify(20'h00700, 2, acc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
